// File: rtl/map_tile_writer_pkg.sv
// Shared map geometry, command opcodes and writer states; the renderer imports the
// same constants so both sides agree on address = x + y*MAP_W.
package map_pkg;
    localparam int MAP_W     = 128;
    localparam int MAP_H     = 128;
    localparam int TILE_BITS = 4;
    localparam int ADDR_BITS = $clog2(MAP_W * MAP_H);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_POINT = 2'd1,
        OP_RECT  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAINT  = 2'd1,
        FINISH = 2'd2
    } wr_state_e;
endpackage

// File: rtl/map_tile_writer_rect_cursor.sv
// Loadable 2-D raster counter, x fastest; one step per cycle, no internal stall.
// last is combinational on the current position so the caller can stop before wrapping.
module map_rect_cursor #(
    parameter int XB = 7,
    parameter int YB = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [XB-1:0] start_x,
    input  logic [YB-1:0] start_y,
    input  logic [XB-1:0] end_x,
    input  logic [YB-1:0] end_y,
    output logic [XB-1:0] cx,
    output logic [YB-1:0] cy,
    output logic          last
);
    logic [XB-1:0] sx_q;
    logic [XB-1:0] ex_q;
    logic [YB-1:0] ey_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx   <= '0;
            cy   <= '0;
            sx_q <= '0;
            ex_q <= '0;
            ey_q <= '0;
        end else if (load) begin
            cx   <= start_x;
            cy   <= start_y;
            sx_q <= start_x;
            ex_q <= end_x;
            ey_q <= end_y;
        end else if (step) begin
            if (cx == ex_q) begin
                cx <= sx_q;
                cy <= cy + YB'(1);
            end else begin
                cx <= cx + XB'(1);
            end
        end
    end

    assign last = (cx == ex_q) && (cy == ey_q);
endmodule

// File: rtl/map_tile_writer.sv
// Paints POINT/RECT/CLEAR commands into the tile-map RAM, one write per clock; first write
// one cycle after acceptance. No queueing: ready only in IDLE. MAP_TILE_WRITER_NORMALIZE_EN swaps inverted RECT corners.
module map_tile_writer #(
    parameter int WIDTH     = map_pkg::MAP_W,
    parameter int HEIGHT    = map_pkg::MAP_H,
    parameter int TILE_BITS = map_pkg::TILE_BITS
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_in,
    input  logic                              cmd_valid_in,
    output logic                              cmd_ready_out,
    input  logic [1:0]                        cmd_op_in,
    input  logic [$clog2(WIDTH)-1:0]          x0_in,
    input  logic [$clog2(HEIGHT)-1:0]         y0_in,
    input  logic [$clog2(WIDTH)-1:0]          x1_in,
    input  logic [$clog2(HEIGHT)-1:0]         y1_in,
    input  logic [TILE_BITS-1:0]              tile_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic [TILE_BITS-1:0]              wr_data_out,
    output logic                              wr_en_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              err_out
);
    import map_pkg::*;

    localparam int XB = $clog2(WIDTH);
    localparam int YB = $clog2(HEIGHT);

    wr_state_e      state;
    cmd_op_e        op;
    logic [XB-1:0]  sx, ex, cx;
    logic [YB-1:0]  sy, ey, cy;
    logic           inverted;
    logic           accept;
    logic           load;
    logic           step;
    logic           last;
    logic [TILE_BITS-1:0] tile_q;

    assign op = cmd_op_e'(cmd_op_in);

    // Resolve the painted region's start/end corners straight from the command fields.
    always_comb begin
        sx       = x0_in;
        sy       = y0_in;
        ex       = x0_in;
        ey       = y0_in;
        inverted = 1'b0;
        case (op)
            OP_RECT: begin
`ifdef MAP_TILE_WRITER_NORMALIZE_EN
                sx = (x1_in < x0_in) ? x1_in : x0_in;
                ex = (x1_in < x0_in) ? x0_in : x1_in;
                sy = (y1_in < y0_in) ? y1_in : y0_in;
                ey = (y1_in < y0_in) ? y0_in : y1_in;
`else
                ex       = x1_in;
                ey       = y1_in;
                inverted = (x1_in < x0_in) || (y1_in < y0_in);
`endif
            end
            OP_CLEAR: begin
                sx = '0;
                sy = '0;
                ex = '1;
                ey = '1;
            end
            default: ;
        endcase
    end

    assign cmd_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign accept        = cmd_valid_in && cmd_ready_out;
    assign load          = accept && (op != OP_NOP) && !inverted;
    assign step          = (state == PAINT) && !last;

    map_rect_cursor #(.XB(XB), .YB(YB)) u_cursor (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .load    (load),
        .step    (step),
        .start_x (sx),
        .start_y (sy),
        .end_x   (ex),
        .end_y   (ey),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            wr_en_out <= 1'b0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
            tile_q    <= '0;
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_NOP) begin
                            done_out <= 1'b1;
                        end else if (inverted) begin
                            err_out <= 1'b1;
                        end else begin
                            state     <= PAINT;
                            wr_en_out <= 1'b1;
                            tile_q    <= tile_in;
                        end
                    end
                end
                PAINT: begin
                    if (last) begin
                        state     <= FINISH;
                        wr_en_out <= 1'b0;
                        done_out  <= 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The cursor flops are the write address; they advance on the same edge as the FSM.
    assign wr_addr_out = {cy, cx};
    assign wr_data_out = tile_q;
endmodule

// File: tb/tb_map_tile_writer.sv
// Directed bench for map_tile_writer: table of commands with hand-computed write counts,
// corner addresses and pulse timing, plus held-valid and mid-command reset sequences.
module tb_map_tile_writer;
    import map_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [6:0]  x0 = '0, x1 = '0;
    logic [6:0]  y0 = '0, y1 = '0;
    logic [3:0]  tile = '0;
    logic [13:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_en, busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    map_tile_writer dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .cmd_valid_in  (cmd_valid),
        .cmd_ready_out (cmd_ready),
        .cmd_op_in     (cmd_op),
        .x0_in         (x0),
        .y0_in         (y0),
        .x1_in         (x1),
        .y1_in         (y1),
        .tile_in       (tile),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .wr_en_out     (wr_en),
        .busy_out      (busy),
        .done_out      (done),
        .err_out       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [1:0] op;
        int         x0, y0, x1, y1, tile;
        int         k;        // tiles written
        int         first_a;  // first write address (-1 if none)
        int         last_a;   // last write address (-1 if none)
        bit         rej;      // rejected with err pulse
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input int ax0, input int ay0,
                         input int ax1, input int ay1, input int t);
        cmd_op = o;
        x0 = 7'(ax0);
        y0 = 7'(ay0);
        x1 = 7'(ax1);
        y1 = 7'(ay1);
        tile = 4'(t);
    endtask

    task automatic run_cmd(input vec_t v);
        int exp_a[$];
        int bx0, by0, bx1, by1;
        int nw = 0, seq_bad = 0, busy_bad = 0;
        int first_a = -1, last_a = -1;
        int done_cyc = -1, n_done = 0, err_cyc = -1, n_err = 0, ready_after = -1;
        bx0 = v.x0; by0 = v.y0; bx1 = v.x0; by1 = v.y0;
        if (v.op == OP_RECT) begin
            bx0 = (v.x1 < v.x0) ? v.x1 : v.x0;
            bx1 = (v.x1 < v.x0) ? v.x0 : v.x1;
            by0 = (v.y1 < v.y0) ? v.y1 : v.y0;
            by1 = (v.y1 < v.y0) ? v.y0 : v.y1;
        end else if (v.op == OP_CLEAR) begin
            bx0 = 0; by0 = 0; bx1 = 127; by1 = 127;
        end
        if (v.op != OP_NOP && !v.rej)
            for (int yy = by0; yy <= by1; yy++)
                for (int xx = bx0; xx <= bx1; xx++)
                    exp_a.push_back(yy * 128 + xx);

        @(negedge clk);
        chk({v.name, "/ready_before"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        drive(v.op, v.x0, v.y0, v.x1, v.y1, v.tile);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drive(OP_CLEAR, 77, 66, 1, 2, ~v.tile);
        for (int c = 1; c <= v.k + 8; c++) begin
            @(negedge clk);
            if (wr_en) begin
                if (nw >= exp_a.size() || int'(wr_addr) != exp_a[nw] ||
                    int'(wr_data) != v.tile || c != nw + 1)
                    seq_bad++;
                if (first_a < 0) first_a = int'(wr_addr);
                last_a = int'(wr_addr);
                nw++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
            if (err) begin
                if (err_cyc < 0) err_cyc = c;
                n_err++;
            end
            if (c == v.k + 2) ready_after = int'(cmd_ready);
            if (v.op != OP_NOP && !v.rej && c <= v.k + 1 && !busy) busy_bad++;
            if ((v.op == OP_NOP || v.rej) && busy) busy_bad++;
        end
        chk({v.name, "/nwrites"},     nw, v.k);
        chk({v.name, "/seq_bad"},     seq_bad, 0);
        chk({v.name, "/first_addr"},  first_a, v.first_a);
        chk({v.name, "/last_addr"},   last_a, v.last_a);
        chk({v.name, "/done_cycle"},  done_cyc, v.rej ? -1 : v.k + 1);
        chk({v.name, "/done_pulses"}, n_done, v.rej ? 0 : 1);
        chk({v.name, "/err_cycle"},   err_cyc, v.rej ? 1 : -1);
        chk({v.name, "/err_pulses"},  n_err, v.rej ? 1 : 0);
        chk({v.name, "/ready_after"}, ready_after, 1);
        chk({v.name, "/busy_bad"},    busy_bad, 0);
    endtask

    initial begin
        int wc[$], wa[$], wd[$];
        int nd;
        int ready5, ready6;
        int exp_c[5] = '{1, 2, 3, 4, 7};
        int exp_a[5] = '{130, 131, 258, 259, 0};
        int exp_d[5] = '{10, 10, 10, 10, 1};

        vecs[0] = '{"point",      OP_POINT, 5, 3, 0, 0, 7,    1,     389,   389,   1'b0};
        vecs[1] = '{"rect2x2",    OP_RECT,  2, 1, 3, 2, 10,   4,     130,   259,   1'b0};
        vecs[2] = '{"nop",        OP_NOP,   9, 9, 9, 9, 3,    0,     -1,    -1,    1'b0};
        vecs[3] = '{"vline",      OP_RECT,  10, 20, 10, 25, 3, 6,    2570,  3210,  1'b0};
        vecs[4] = '{"corner",     OP_RECT,  127, 127, 127, 127, 15, 1, 16383, 16383, 1'b0};
        vecs[5] = '{"hline_edge", OP_RECT,  120, 0, 127, 0, 1, 8,    120,   127,   1'b0};
`ifdef MAP_TILE_WRITER_NORMALIZE_EN
        vecs[6] = '{"inverted",   OP_RECT,  9, 2, 4, 2, 5,    6,     260,   265,   1'b0};
`else
        vecs[6] = '{"inverted",   OP_RECT,  9, 2, 4, 2, 5,    0,     -1,    -1,    1'b1};
`endif
        vecs[7] = '{"clear",      OP_CLEAR, 3, 3, 1, 1, 0,    16384, 0,     16383, 1'b0};
        vecs[8] = '{"point_org",  OP_POINT, 0, 0, 5, 5, 9,    1,     0,     0,     1'b0};

        // Reset state
        #2;
        chk("rst/wr_en", int'(wr_en), 0);
        chk("rst/done",  int'(done), 0);
        chk("rst/err",   int'(err), 0);
        chk("rst/busy",  int'(busy), 0);
        chk("rst/addr",  int'(wr_addr), 0);
        chk("rst/data",  int'(wr_data), 0);
        chk("rst/ready", int'(cmd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Valid held high through a RECT while the fields change underneath it
        @(negedge clk);
        cmd_valid = 1'b1;
        drive(OP_RECT, 2, 1, 3, 2, 10);
        @(posedge clk);
        #1;
        drive(OP_POINT, 0, 0, 0, 0, 1);
        nd = 0; ready5 = -1; ready6 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (wr_en) begin
                wc.push_back(c);
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
            end
            if (done) nd++;
            if (c == 5) ready5 = int'(cmd_ready);
            if (c == 6) ready6 = int'(cmd_ready);
            if (c == 7) cmd_valid = 1'b0;
        end
        chk("held/nwrites", wc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wc.size()) begin
                chk($sformatf("held/w%0d_cycle", i), wc[i], exp_c[i]);
                chk($sformatf("held/w%0d_addr", i),  wa[i], exp_a[i]);
                chk($sformatf("held/w%0d_data", i),  wd[i], exp_d[i]);
            end
        end
        chk("held/done_pulses", nd, 2);
        chk("held/ready_c5", ready5, 0);
        chk("held/ready_c6", ready6, 1);

        // Asynchronous reset in the middle of a long RECT
        @(negedge clk);
        cmd_valid = 1'b1;
        drive(OP_RECT, 0, 0, 127, 3, 6);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid/wr_en_before", int'(wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid/wr_en_async", int'(wr_en), 0);
        chk("rstmid/busy_async",  int'(busy), 0);
        chk("rstmid/ready_async", int'(cmd_ready), 1);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3) rst = 1'b0;
            if (done || wr_en) nd++;
        end
        chk("rstmid/no_done_or_write", nd, 0);
        chk("rstmid/ready_after", int'(cmd_ready), 1);
        run_cmd(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/map_tile_writer.md
Name: map_tile_writer

Overview:
- Write-side counterpart of the map renderer.
- Accepts paint commands (single tile, rectangle, whole-map clear) over a valid/ready handshake.
- Emits one tile write per clock into the write port of the tile-map RAM that the renderer reads.
- Sits between game logic or UART loader and the map RAM. Renderer reads address {y,x} = x + y*WIDTH; this block writes with the same mapping.

Parameters:
- WIDTH, 128, map width in tiles (power of two)
- HEIGHT, 128, map height in tiles (power of two)
- TILE_BITS, 4, bits per tile index (palette address)

Ports:
- pixel_clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- cmd_valid_in  input  1  command present
- cmd_ready_out  output  1  block can accept a command
- cmd_op_in  input  2  0=NOP, 1=POINT, 2=RECT, 3=CLEAR
- x0_in  input  $clog2(WIDTH)  first x / point x
- y0_in  input  $clog2(HEIGHT)  first y / point y
- x1_in  input  $clog2(WIDTH)  last x (RECT, inclusive)
- y1_in  input  $clog2(HEIGHT)  last y (RECT, inclusive)
- tile_in  input  TILE_BITS  tile value to paint
- wr_addr_out  output  $clog2(WIDTH*HEIGHT)  RAM write address
- wr_data_out  output  TILE_BITS  RAM write data
- wr_en_out  output  1  RAM write strobe
- busy_out  output  1  command in progress
- done_out  output  1  one-cycle pulse, command finished
- err_out  output  1  one-cycle pulse, command rejected

Behaviour:
- Clock and reset: single clock pixel_clk_in. rst_in is asynchronous active-high. While in reset:
  - state=IDLE
  - wr_en_out, done_out, err_out, busy_out = 0
  - wr_addr_out and wr_data_out = 0
  - cmd_ready_out = 1
- States: IDLE, PAINT, FINISH.
- Handshake: cmd_ready_out = (state==IDLE), combinational from state. A command is accepted on the rising edge where cmd_valid_in & cmd_ready_out. All command fields (op, corners, tile) are latched on acceptance; inputs are ignored afterwards.
- IDLE, NOP accepted: done_out pulses next cycle; no writes.
- IDLE, POINT/RECT/CLEAR accepted: go to PAINT.
  - Cursor is loaded with (x0,y0), or (0,0) for CLEAR.
  - End corner is (x0,y0) for POINT, (x1,y1) for RECT, (WIDTH-1,HEIGHT-1) for CLEAR.
- PAINT:
  - Every cycle: wr_en_out=1, wr_addr_out={cy,cx}, wr_data_out=latched tile. All three are registered.
  - Raster order, x fastest: cx increments; at cx==end_x, cx←start_x and cy increments. At (end_x,end_y), go to FINISH.
- FINISH: done_out=1 for one cycle, wr_en_out=0, then IDLE.
- busy_out = (state != IDLE).
- Timing:
  - Acceptance edge N: first write visible in cycle N+1.
  - Last write visible in cycle N+k, where k = tile count.
  - done_out in cycle N+k+1; cmd_ready_out=1 from cycle N+k+2.
  - POINT: k=1. RECT: k=(x1-x0+1)*(y1-y0+1). CLEAR: k=WIDTH*HEIGHT.
- Arithmetic: cursor counters are exactly $clog2 wide. The end-compare prevents wrap. A RECT with x0==x1 and/or y0==y1 is legal (line or single tile).
- Invalid RECT (x1<x0 or y1<y0), macro absent: no writes; err_out pulses in cycle N+1; state stays IDLE, so ready stays 1.
- Reset mid-PAINT: writes stop immediately (wr_en_out=0 asynchronously). No done_out. Partially painted tiles remain in RAM.
- cmd_valid_in held high while busy: ignored. No queueing.

Optional Feature:
- Macro MAP_TILE_WRITER_NORMALIZE_EN.
- Defined: an inverted RECT is accepted with its corners swapped per axis (min→start, max→end), and painted normally. err_out is tied to 0.
- Undefined: an inverted RECT is rejected as described in Behaviour.

Decomposition:
- Package map_pkg:
  - MAP_W, MAP_H, TILE_BITS constants
  - localparam ADDR_BITS
  - typedef enum for cmd_op (OP_NOP, OP_POINT, OP_RECT, OP_CLEAR)
  - typedef enum for writer state
  - This package is shared with the renderer so the address mapping matches.
- One natural sub-module, map_rect_cursor: loadable 2-D raster counter with start/end corners, step input and last flag. The FSM and the handshake stay in the top module.

Test Plan:
- POINT (x0=5, y0=3, tile=7): exactly one write, addr=3*128+5=389, data=7, at N+1; done_out at N+2; ready at N+3.
- RECT (2,1)-(3,2), tile=A: writes in order 130, 131, 258, 259 on consecutive cycles; done_out at N+5.
- CLEAR, tile=0: 16384 writes, addr 0..16383 contiguous; done_out at N+16385; busy_out high throughout.
- Inverted RECT (x0=9, x1=4): without macro, zero writes, err_out pulse at N+1, ready stays 1. With the macro, columns 4..9 are painted and err_out stays 0.
- cmd_valid_in held high during a RECT: no second acceptance until ready returns; queued fields changed mid-command do not alter the writes.
- rst_in asserted mid-RECT (asynchronously, between clock edges): wr_en_out drops without waiting for an edge, no done_out, ready=1 after release; a following POINT completes normally.
